// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file constants and types, used by the register
// file and by rf_write_arbiter.
//   RF_DATA_W  register data width
//   RF_ADDR_W  register address width
//   RF_NREGS   number of architectural registers
package rf_pkg;
   localparam int RF_DATA_W = 16;
   localparam int RF_ADDR_W = 3;
   localparam int RF_NREGS  = 8;

   typedef logic [RF_ADDR_W-1:0] rf_addr_t;
   typedef logic [RF_DATA_W-1:0] rf_data_t;
endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// rr_arbiter: N_REQ-wide round-robin grant with pointer update.
//   clk, rst    clock, synchronous active-high reset
//   req_valid_i request vector
//   gnt_o       one-hot grant (zero when no request), combinational
//   gnt_idx_o   index of the granted requester
//   gnt_any_o   a grant is issued this cycle
// The search starts at the pointer and wraps. After a grant the pointer
// moves to one past the winner, so a requester that stays valid waits
// behind at most N_REQ-1 other grants.
module rr_arbiter #(
   parameter int N_REQ = 3,
   parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req_valid_i,
   output logic [N_REQ-1:0] gnt_o,
   output logic [PTR_W-1:0] gnt_idx_o,
   output logic             gnt_any_o
);
   logic [PTR_W-1:0] ptr_q, ptr_d;

   always_comb begin
      int idx;
      gnt_o     = '0;
      gnt_idx_o = '0;
      gnt_any_o = 1'b0;
      ptr_d     = ptr_q;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!gnt_any_o && req_valid_i[idx]) begin
            gnt_any_o  = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_idx_o  = PTR_W'(idx);
            ptr_d      = (idx == N_REQ-1) ? '0 : PTR_W'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port among N_REQ
// writeback requesters (round robin, valid/ready) and keeps a busy
// scoreboard for read-after-write hazard detection.
//   clk, rst         clock, synchronous active-high reset
//   req_valid/dest/data  per-requester write requests (slice i)
//   req_ready        one-hot accept, combinational
//   rsv_valid/dest   issue-stage destination reservation
//   busy             per-register outstanding-write flags
//   reg_write_*      registered register-file write port
// Build option: RF_WRITE_R0_DISCARD_EN makes register 0 hard-wired (writes to
// it are accepted but dropped, reservations of it are ignored).
import rf_pkg::*;

module rf_write_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*ADDR_W-1:0] req_dest,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   output logic [N_REQ-1:0]        req_ready,
   input  logic                    rsv_valid,
   input  logic [ADDR_W-1:0]       rsv_dest,
   output logic [(2**ADDR_W)-1:0]  busy,
   output logic                    reg_write_en,
   output logic [ADDR_W-1:0]       reg_write_dest,
   output logic [DATA_W-1:0]       reg_write_data
);
   localparam int NREGS = 2**ADDR_W;
   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0]  gnt_idx;
   logic              xfer;
   logic [ADDR_W-1:0] sel_dest;
   logic [DATA_W-1:0] sel_data;
   logic              wr_keep, rsv_keep;

   logic              we_q, we_d;
   logic [ADDR_W-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [NREGS-1:0]  busy_q, busy_d;

   rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
      .clk         (clk),
      .rst         (rst),
      .req_valid_i (req_valid),
      .gnt_o       (req_ready),
      .gnt_idx_o   (gnt_idx),
      .gnt_any_o   (xfer)
   );

   assign sel_dest = req_dest[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_data = req_data[int'(gnt_idx)*DATA_W +: DATA_W];

`ifdef RF_WRITE_R0_DISCARD_EN
   // r0 is hard-wired: accepted writes to it never reach the register file
   assign wr_keep  = (sel_dest != '0);
   assign rsv_keep = (rsv_dest != '0);
`else
   assign wr_keep  = 1'b1;
   assign rsv_keep = 1'b1;
`endif

   always_comb begin
      we_d   = xfer && wr_keep;
      dest_d = xfer ? sel_dest : dest_q;
      data_d = xfer ? sel_data : data_q;
      busy_d = busy_q;
      // retire first so a same-cycle reservation of the same register wins
      if (we_q)                  busy_d[dest_q]   = 1'b0;
      if (rsv_valid && rsv_keep) busy_d[rsv_dest] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         we_q   <= 1'b0;
         dest_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         we_q   <= we_d;
         dest_q <= dest_d;
         data_q <= data_d;
         busy_q <= busy_d;
      end
   end

   assign reg_write_en   = we_q;
   assign reg_write_dest = dest_q;
   assign reg_write_data = data_q;
   assign busy           = busy_q;
endmodule
